// File: rtl/control_sequencer.sv
// Multicycle datapath next-state controller: sequences fetch/decode/execute
// states, stalls on memory handshakes, traps on illegal opcodes, counts retirements.
module control_sequencer #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_ready,
    input  logic [31:0]        mem_rdata,
    input  logic               halt_req,
    output logic [3:0]         state,
    output logic [5:0]         opcode,
    output logic               instr_done,
    output logic [COUNT_W-1:0] retired_count,
    output logic               trap
);

    localparam int unsigned ST_W = 4;
    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_LDI  = 6'h20;
    localparam logic [OP_W-1:0] OP_LD   = 6'h21;
    localparam logic [OP_W-1:0] OP_STR  = 6'h22;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'h23;
    localparam logic [OP_W-1:0] OP_BNE  = 6'h24;
    localparam logic [OP_W-1:0] OP_JUMP = 6'h25;

    typedef enum logic [ST_W-1:0] {
        S_IF      = 4'd0,
        S_RF      = 4'd1,
        S_IMM2    = 4'd2,
        S_ALU_R3  = 4'd3,
        S_ALU_RI3 = 4'd4,
        S_ALU4    = 4'd5,
        S_BRANCH3 = 4'd6,
        S_MEMREF3 = 4'd7,
        S_LOAD4   = 4'd8,
        S_STORE4  = 4'd9,
        S_LOAD5   = 4'd10,
        S_JUMP3   = 4'd11,
        S_TRAP    = 4'd15
    } state_e;

    state_e             state_q, state_d;
    logic [OP_W-1:0]    opcode_q, opcode_d;
    logic               done_q, done_d;
    logic               trap_q, trap_d;
    logic [COUNT_W-1:0] count_q;

    // Only the opcode field of the fetched word matters here.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata[25:0];

    // State, opcode and retirement registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IF;
            opcode_q <= '0;
            done_q   <= 1'b0;
            trap_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            done_q   <= done_d;
            trap_q   <= trap_d;
            if (done_d) begin
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

    // Next-state decode; done_d marks transitions that retire an instruction.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        done_d   = 1'b0;
        case (state_q)
            S_IF: begin
                if (!halt_req && mem_ready) begin
                    opcode_d = mem_rdata[31:26];
                    state_d  = S_RF;
                end
            end
            S_RF: begin
                if (opcode_q[5:4] == 2'b00) begin
                    state_d = S_ALU_R3;
                end else if (opcode_q[5:4] == 2'b01) begin
                    state_d = S_ALU_RI3;
                end else begin
                    case (opcode_q)
                        OP_LDI:         state_d = S_IMM2;
                        OP_LD, OP_STR:  state_d = S_MEMREF3;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH3;
                        OP_JUMP:        state_d = S_JUMP3;
                        default:        state_d = S_TRAP;
                    endcase
                end
            end
            S_ALU_R3, S_ALU_RI3: state_d = S_ALU4;
            S_ALU4, S_IMM2, S_BRANCH3, S_JUMP3, S_LOAD5: begin
                state_d = S_IF;
                done_d  = 1'b1;
            end
            S_MEMREF3: begin
                if (opcode_q == OP_LD) begin
                    state_d = S_LOAD4;
                end else if (opcode_q == OP_STR) begin
                    state_d = S_STORE4;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_LOAD4: begin
                if (mem_ready) begin
                    state_d = S_LOAD5;
                end
            end
            S_STORE4: begin
                if (mem_ready) begin
                    state_d = S_IF;
                    done_d  = 1'b1;
                end
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        trap_d = (state_d == S_TRAP);
    end

    assign state         = state_q;
    assign opcode        = opcode_q;
    assign instr_done    = done_q;
    assign retired_count = count_q;
    assign trap          = trap_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed plus randomized bench for control_sequencer: a per-instruction model
// expands each opcode class into its expected state trace and retirement effects.
module tb_control_sequencer;

    localparam int unsigned CW   = 4;
    localparam int          MASK = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic          halt_req;
    logic [3:0]    state;
    logic [5:0]    opcode;
    logic          instr_done;
    logic [CW-1:0] retired_count;
    logic          trap;

    int checks = 0;
    int errors = 0;

    int exp_op   = 0;
    int exp_cnt  = 0;
    int exp_done = 0;

    control_sequencer #(.COUNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .halt_req      (halt_req),
        .state         (state),
        .opcode        (opcode),
        .instr_done    (instr_done),
        .retired_count (retired_count),
        .trap          (trap)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input int st);
        chk("state", 32'(state), 32'(st));
        chk("opcode", 32'(opcode), 32'(exp_op));
        chk("instr_done", 32'(instr_done), 32'(exp_done));
        chk("retired_count", 32'(retired_count), 32'(exp_cnt));
        chk("trap", 32'(trap), 32'(st == 15));
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear before any edge.
    task automatic mid_reset();
        rst_n = 1'b0;
        #2;
        exp_op = 0; exp_cnt = 0; exp_done = 0;
        chk_all(0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Runs one instruction; abort_at >= 0 asserts reset at that cycle index.
    task automatic run_instr(input int op, input int nhalt, input int nifstall,
                             input int nmemstall, input int abort_at);
        int st_q[$];
        bit rdy_q[$];
        bit hlt_q[$];
        bit fetch_q[$];
        bit legal;
        legal = (op <= 'h25);
        for (int h = 0; h < nhalt; h++) begin
            st_q.push_back(0); rdy_q.push_back(1); hlt_q.push_back(1); fetch_q.push_back(0);
        end
        for (int s = 0; s < nifstall; s++) begin
            st_q.push_back(0); rdy_q.push_back(0); hlt_q.push_back(0); fetch_q.push_back(0);
        end
        st_q.push_back(0); rdy_q.push_back(1); hlt_q.push_back(0); fetch_q.push_back(1);
        st_q.push_back(1);
        if (op < 'h10)       begin st_q.push_back(3); st_q.push_back(5); end
        else if (op < 'h20)  begin st_q.push_back(4); st_q.push_back(5); end
        else if (op == 'h20) st_q.push_back(2);
        else if (op == 'h21) begin
            st_q.push_back(7);
            for (int m = 0; m <= nmemstall; m++) st_q.push_back(8);
            st_q.push_back(10);
        end else if (op == 'h22) begin
            st_q.push_back(7);
            for (int m = 0; m <= nmemstall; m++) st_q.push_back(9);
        end else if (op == 'h23 || op == 'h24) st_q.push_back(6);
        else if (op == 'h25) st_q.push_back(11);
        else for (int t = 0; t < 4; t++) st_q.push_back(15);
        // Handshake values past the fetch: low only on memory stall cycles.
        begin
            int mem_seen = 0;
            for (int k = rdy_q.size(); k < st_q.size(); k++) begin
                if (st_q[k] == 8 || st_q[k] == 9) begin
                    rdy_q.push_back(mem_seen == nmemstall);
                    mem_seen++;
                end else begin
                    rdy_q.push_back(1'($urandom_range(0, 1)));
                end
                hlt_q.push_back(1'($urandom_range(0, 1)));
                fetch_q.push_back(0);
            end
        end
        for (int i = 0; i < st_q.size(); i++) begin
            chk_all(st_q[i]);
            exp_done = 0;
            if (i == abort_at) begin
                mid_reset();
                return;
            end
            mem_ready = rdy_q[i];
            halt_req  = hlt_q[i];
            mem_rdata = $urandom;
            if (fetch_q[i]) mem_rdata[31:26] = 6'(op);
            @(posedge clk); #1;
            if (fetch_q[i]) exp_op = op;
        end
        if (legal) begin
            exp_done = 1;
            exp_cnt  = (exp_cnt + 1) & MASK;
        end else begin
            mid_reset();
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = '0; halt_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all(0);
        rst_n = 1'b1;

        run_instr('h00, 0, 0, 0, -1);        // ADD
        run_instr('h21, 0, 0, 2, -1);        // LD with 2 memory stalls
        run_instr('h25, 0, 0, 0, -1);        // JUMP
        run_instr('h22, 0, 1, 0, -1);        // STR with 1 fetch stall
        run_instr('h20, 0, 0, 0, -1);        // LDI
        run_instr('h13, 0, 0, 0, -1);        // I-ALU
        run_instr('h24, 2, 0, 0, -1);        // BNE after halt

        for (int n = 0; n < 40; n++) begin
            run_instr($urandom_range(0, 'h25), $urandom_range(0, 2),
                      $urandom_range(0, 2), $urandom_range(0, 3), -1);
        end

        run_instr($urandom_range(0, 'h0F), 0, 0, 0, 2);   // reset inside ALU_R3
        run_instr('h24, 3, 0, 0, -1);                      // halt holds IF with mem_ready high

        mid_reset();
        for (int n = 0; n < 16; n++) run_instr('h23, 0, 0, 0, -1);  // 16th BEQ wraps count
        run_instr('h00, 0, 0, 0, -1);

        run_instr('h30, 0, 0, 0, -1);                      // illegal, trap then reset
        run_instr($urandom_range('h26, 'h3F), 0, 1, 0, -1);
        run_instr('h21, 0, 0, 0, -1);
        chk_all(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
